// File: rtl/reaction_timer_core_pkg.sv
// Shared definitions for the reaction-time game controller and its display driver.
package reaction_timer_core_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_LIT    = 3'd2,
        S_RESULT = 3'd3,
        S_ERROR  = 3'd4
    } state_e;

    localparam int          MAX_MS_DEFAULT = 9999;
    localparam logic [15:0] LFSR_SEED      = 16'hACE1;

    // One step of the 16-bit Fibonacci LFSR with taps 16,14,13,11; never reaches zero from a non-zero seed.
    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/reaction_timer_core_btn_sync.sv
// Two-flop synchroniser for an asynchronous push button plus rising-edge detection,
// so a button held for any length of time yields a single one-cycle press.
module reaction_timer_core_btn_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Metastability chain followed by a delayed copy used to find the rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press_o = sync2_q & ~prev_q;

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time game controller: random wait, GO LED, millisecond count of the reaction,
// early-press detection, and registered value/error outputs for the 7-segment driver.
module reaction_timer_core
    import reaction_timer_core_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = MAX_MS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_start,
    input  logic        btn_react,
    output logic        led_go,
    output logic [13:0] value,
    output logic        show_error,
    output logic        result_valid
);

    localparam int          TICKS_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int          PW           = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [13:0] MIN_DELAY    = 14'(MIN_DELAY_MS);
    localparam logic [13:0] MAX_VAL      = 14'(MAX_MS);

    logic          startPress;
    logic          reactPress;
    logic          tick;
    logic          enterWait;
    logic          enterLit;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [15:0]   lfsr_q;
    logic [13:0]   delayLoad;
    state_e        state_q;
    logic [13:0]   delayCnt_q;
    logic [13:0]   msCnt_q;
    logic [13:0]   value_q;
    logic          ledGo_q;
    logic          showError_q;
    logic          resultValid_q;

    reaction_timer_core_btn_sync u_startSync (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_start),
        .press_o (startPress)
    );

    reaction_timer_core_btn_sync u_reactSync (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_react),
        .press_o (reactPress)
    );

    // Decode state-entry events and the ms tick; the prescaler restarts on entry so the first ms is full length.
    always_comb begin
        enterWait = startPress && (state_q inside {S_IDLE, S_RESULT, S_ERROR});
        enterLit  = (state_q == S_WAIT) && !reactPress && (delayCnt_q == 14'd0);
        tick      = (presc_q == PRESC_LAST);
        delayLoad = MIN_DELAY + {{(14 - RAND_BITS){1'b0}}, lfsr_q[RAND_BITS-1:0]};
        presc_d   = tick ? '0 : presc_q + PW'(1);
        if (enterWait || enterLit) begin
            presc_d = '0;
        end
    end

    // Millisecond prescaler.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Free-running random source sampled when a round starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsrStep(lfsr_q);
        end
    end

    // Game FSM with all display-facing outputs registered; react has priority over expiry/timeout/tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            delayCnt_q    <= 14'd0;
            msCnt_q       <= 14'd0;
            value_q       <= 14'd0;
            ledGo_q       <= 1'b0;
            showError_q   <= 1'b0;
            resultValid_q <= 1'b0;
        end else begin
            resultValid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_RESULT, S_ERROR: begin
                    if (startPress) begin
                        state_q     <= S_WAIT;
                        delayCnt_q  <= delayLoad;
                        value_q     <= 14'd0;
                        showError_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (reactPress) begin
                        state_q     <= S_ERROR;
                        showError_q <= 1'b1;
                    end else if (delayCnt_q == 14'd0) begin
                        state_q <= S_LIT;
                        msCnt_q <= 14'd0;
                        ledGo_q <= 1'b1;
                    end else if (tick) begin
                        delayCnt_q <= delayCnt_q - 14'd1;
                    end
                end
                S_LIT: begin
                    if (reactPress) begin
                        state_q       <= S_RESULT;
                        value_q       <= msCnt_q;
                        ledGo_q       <= 1'b0;
                        resultValid_q <= 1'b1;
                    end else if (msCnt_q == MAX_VAL) begin
                        state_q       <= S_RESULT;
                        value_q       <= MAX_VAL;
                        ledGo_q       <= 1'b0;
                        resultValid_q <= 1'b1;
                    end else if (tick) begin
                        msCnt_q <= msCnt_q + 14'd1;
                        value_q <= msCnt_q + 14'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign led_go       = ledGo_q;
    assign value        = value_q;
    assign show_error   = showError_q;
    assign result_valid = resultValid_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Randomised scoreboard bench for the reaction-time controller at a small clock rate.
module tb_reaction_timer_core;

    localparam int CLK_HZ = 10_000;
    localparam int T      = CLK_HZ / 1000;
    localparam int MIN_MS = 4;
    localparam int RBITS  = 3;
    localparam int MAXV   = 30;

    typedef struct packed {
        logic        isError;
        logic [13:0] ms;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        btn_start;
    logic        btn_react;
    logic        led_go;
    logic [13:0] value;
    logic        show_error;
    logic        result_valid;

    exp_t        sbQ[$];
    exp_t        monE;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] modelLfsr;
    bit          prevErr = 1'b0;
    bit          prevValid = 1'b0;
    int          d;

    reaction_timer_core #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .MIN_DELAY_MS (MIN_MS),
        .RAND_BITS    (RBITS),
        .MAX_MS       (MAXV)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_start    (btn_start),
        .btn_react    (btn_react),
        .led_go       (led_go),
        .value        (value),
        .show_error   (show_error),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Pseudo-random sequence as defined for the game: 16-bit Fibonacci, taps 16,14,13,11.
    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference random generator, advancing once per clock from the seed.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) modelLfsr <= 16'hACE1;
        else          modelLfsr <= lfsrNext(modelLfsr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: each result pulse or rising error flag is matched against the next expected outcome.
    always @(negedge clk) begin
        if (reset_n) begin
            if (result_valid) begin
                checkOutput("rvPulseWidth", prevValid, 0);
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedResult: got value %0d expected no result", value);
                end else begin
                    monE = sbQ.pop_front();
                    checkOutput("resultKind", show_error, monE.isError);
                    checkOutput("resultValue", value, monE.ms);
                    checkOutput("ledAfterResult", led_go, 0);
                end
            end
            if (show_error && !prevErr) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedError: got show_error 1 expected no outcome");
                end else begin
                    monE = sbQ.pop_front();
                    checkOutput("errorKind", show_error, monE.isError);
                    checkOutput("errorValue", value, monE.ms);
                    checkOutput("ledInError", led_go, 0);
                end
            end
            prevErr   = show_error;
            prevValid = result_valid;
        end else begin
            prevErr   = 1'b0;
            prevValid = 1'b0;
        end
    end

    task automatic applyStimulus(input logic startLvl, input logic reactLvl);
        btn_start = startLvl;
        btn_react = reactLvl;
    endtask

    // Press start at the current falling edge; the expected wait comes from the random value the
    // controller sees when the press reaches it, two clocks after the pad rises.
    task automatic pressStart(output int expD, input bit fromError);
        logic [15:0] l;
        l = lfsrNext(lfsrNext(modelLfsr));
        expD = MIN_MS + int'(l[RBITS-1:0]);
        btn_start = 1'b1;
        repeat (2) @(negedge clk);
        if (fromError) checkOutput("errHeldBeforeStart", show_error, 1);
        @(negedge clk);
        btn_start = 1'b0;
        checkOutput("waitEntryErr", show_error, 0);
        checkOutput("waitEntryValue", value, 0);
    endtask

    task automatic waitGo(input int expD);
        int n;
        n = 0;
        while (led_go !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("waitLenCycles", n, expD * T + 1);
    endtask

    // Called at the first falling edge with GO lit; m < 0 means never react (timeout).
    task automatic reactAt(input int m);
        exp_t e;
        int   v;
        int   n;
        v = (m < 0) ? MAXV : (m + 2) / T;
        if (v > MAXV) v = MAXV;
        e.isError = 1'b0;
        e.ms      = 14'(v);
        sbQ.push_back(e);
        if (m >= 0) begin
            repeat (m) @(negedge clk);
            btn_react = 1'b1;
            repeat (3) @(negedge clk);
            btn_react = 1'b0;
        end
        n = 0;
        while (led_go === 1'b1 && n < (MAXV + 3) * T) begin
            @(negedge clk);
            n++;
        end
        if (n >= (MAXV + 3) * T) checkOutput("litEndsBound", led_go, 0);
        repeat (3) @(negedge clk);
    endtask

    // Called right after pressStart; presses react e clocks into the wait (e <= expD*T-2).
    task automatic earlyReact(input int expD, input int e);
        exp_t x;
        bit   sawGo;
        int   n;
        x.isError = 1'b1;
        x.ms      = 14'd0;
        sbQ.push_back(x);
        sawGo = 1'b0;
        for (int i = 0; i < e; i++) begin
            @(negedge clk);
            if (led_go) sawGo = 1'b1;
        end
        btn_react = 1'b1;
        repeat (3) @(negedge clk);
        if (led_go) sawGo = 1'b1;
        btn_react = 1'b0;
        n = 0;
        while (show_error !== 1'b1 && n < 20) begin
            @(negedge clk);
            if (led_go) sawGo = 1'b1;
            n++;
        end
        checkOutput("errorRaised", show_error, 1);
        checkOutput("noGoBeforeError", sawGo, 0);
        if (expD < 0) $display("[TB] negative delay %0d", expD);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rstLed", led_go, 0);
        checkOutput("rstValue", value, 0);
        checkOutput("rstErr", show_error, 0);
        checkOutput("rstValid", result_valid, 0);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("idleLed", led_go, 0);
        checkOutput("idleValue", value, 0);
        checkOutput("idleErr", show_error, 0);
        checkOutput("idleValid", result_valid, 0);

        // Normal round, react 25 ms after GO.
        pressStart(d, 1'b0);
        waitGo(d);
        reactAt(250);

        // Early press, then restart from the error state; react lands on a tick at ms 7.
        pressStart(d, 1'b0);
        earlyReact(d, 5);
        pressStart(d, 1'b1);
        waitGo(d);
        reactAt(8 * T - 3);

        // React in the same cycle the wait expires counts as early.
        pressStart(d, 1'b0);
        earlyReact(d, d * T - 2);

        // Start and react pressed together, react then held 200 clocks: one start only, ending in timeout.
        applyStimulus(1'b0, 1'b1);
        fork
            begin
                repeat (200) @(negedge clk);
                btn_react = 1'b0;
            end
        join_none
        pressStart(d, 1'b0);
        waitGo(d);
        reactAt(-1);

        // Randomised rounds.
        for (int i = 0; i < 10; i++) begin
            pressStart(d, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                earlyReact(d, int'($urandom_range(0, d * T - 2)));
            end else begin
                waitGo(d);
                reactAt(int'($urandom_range(0, (MAXV + 2) * T)));
            end
        end

        // Asynchronous reset in the middle of GO.
        pressStart(d, 1'b0);
        waitGo(d);
        repeat (50) @(negedge clk);
        checkOutput("liveValue", value, 5);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncRstLed", led_go, 0);
        checkOutput("asyncRstValue", value, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b1);
        repeat (5) @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        repeat (100) @(negedge clk);
        checkOutput("postRstLed", led_go, 0);
        checkOutput("postRstErr", show_error, 0);
        checkOutput("postRstValue", value, 0);

        // Start still works after the reset.
        pressStart(d, 1'b0);
        waitGo(d);
        reactAt(30);

        checkOutput("scoreboardDrained", sbQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
